// File: rtl/mult_pkg.sv
// Shared definitions for the iterative array multiplier slice.
//   - state_t   : sequencer states (IDLE, ROW, RESOLVE, DONE)
//   - MULT_W    : default operand width
//   - ROW_COUNT : number of carry-save row iterations per multiply
package mult_pkg;

    localparam int unsigned MULT_W    = 8;
    localparam int unsigned ROW_COUNT = MULT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROW     = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/carry_save_row.sv
// One combinational row of an array multiplier: N independent full adders.
// Ports:
//   pp      [N-1:0] in  : partial product for this row
//   s       [N-1:0] in  : incoming sum vector
//   c       [N-1:0] in  : incoming carry vector (same weight as s)
//   sum_out [N-1:0] out : per-bit sum
//   c_out   [N-1:0] out : per-bit carry (weight one position higher)
module carry_save_row
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_W
) (
    input  logic [N-1:0] pp,
    input  logic [N-1:0] s,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum_out,
    output logic [N-1:0] c_out
);

    always_comb begin
        sum_out = pp ^ s ^ c;
        c_out   = (pp & s) | (pp & c) | (s & c);
    end

endmodule

// File: rtl/array_mult_sequencer.sv
// Iterative N x N unsigned multiplier reusing a single carry-save row for N
// cycles, then resolving the remaining sum/carry pair with one adder.
// Ports:
//   clk      in          : rising-edge clock
//   rst_n    in          : asynchronous active-low reset
//   start    in          : request a multiply (honoured in IDLE or DONE)
//   a, b     in  [N-1:0] : operands, latched when start is accepted
//   product  out [2N-1:0]: registered result, held until the next done
//   busy     out         : high while rows or the resolve step are running
//   done     out         : one-cycle pulse, product valid in that cycle
module array_mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int unsigned    IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_s;
    logic [N-1:0]    r_c;
    logic [N-1:0]    r_plo;
    logic [IW-1:0]   r_idx;
    logic [2*N-1:0]  r_product;

    logic [N-1:0]    w_pp;
    logic [N-1:0]    w_sum;
    logic [N-1:0]    w_cout;
    logic [N-1:0]    w_phi;

    always_comb begin
        w_pp  = r_a & {N{r_b[r_idx]}};
        // Carry-out is dropped: the residual s + c always fits in N bits.
        w_phi = r_s + r_c;
    end

    carry_save_row #(.N(N)) u_row (
        .pp      (w_pp),
        .s       (r_s),
        .c       (r_c),
        .sum_out (w_sum),
        .c_out   (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ROW;
                end
            end
            ROW: begin
                busy = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_next = RESOLVE;
                end
            end
            RESOLVE: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ROW;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Each row retires its LSB into p_lo; the sum vector shifts down one
    // weight while carries already sit one weight higher, so they stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= '0;
            r_c       <= '0;
            r_plo     <= '0;
            r_idx     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_s   <= '0;
            r_c   <= '0;
            r_plo <= '0;
            r_idx <= '0;
        end else if (r_state == ROW) begin
            r_plo[r_idx] <= w_sum[0];
            r_s          <= {1'b0, w_sum[N-1:1]};
            r_c          <= w_cout;
            r_idx        <= r_idx + IW'(1);
        end else if (r_state == RESOLVE) begin
            r_product <= {w_phi, r_plo};
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_array_mult_sequencer.sv
// Self-checking bench for array_mult_sequencer (N = 8): directed cases plus a
// randomized sweep compared against plain a*b arithmetic.
module tb_array_mult_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;
    logic [15:0] last_exp;

    array_mult_sequencer #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a sample; lat is the number of edges since the drive
    // of start that led to acceptance. Returns when done is seen or bound hit.
    task automatic wait_done(input int lat_init, output int lat, output int bcnt);
        lat  = lat_init;
        bcnt = 0;
        while (!done && lat < 30) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic do_mult(input logic [7:0] aa, input logic [7:0] bb, input string tag);
        int lat;
        int bcnt;
        logic [15:0] exp;
        exp   = 16'(aa) * 16'(bb);
        a     = aa;
        b     = bb;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = $urandom_range(0, 255);
        b     = $urandom_range(0, 255);
        check_eq({tag, "_hold"}, product, last_exp);
        wait_done(1, lat, bcnt);
        check_eq({tag, "_lat"}, lat, 10);
        check_eq({tag, "_busy"}, bcnt, 9);
        check_eq({tag, "_prod"}, product, exp);
        step();
        check_eq({tag, "_donew"}, done, 1'b0);
        last_exp = exp;
    endtask

    initial begin
        int lat;
        int bcnt;
        int extra;
        n_tests  = 0;
        n_fail   = 0;
        last_exp = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_prod", product, 16'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_mult(8'h0D, 8'h0B, "d0d0b");
        check_eq("d0d0b_val", last_exp, 16'h008F);
        do_mult(8'hFF, 8'hFF, "dff");
        do_mult(8'h00, 8'hA5, "dzero");
        do_mult(8'h80, 8'h02, "dpow");

        // start during ROW must be ignored, no second result
        a = 8'd3; b = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 8'd7; b = 8'd7; start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        wait_done(5, lat, bcnt);
        check_eq("ign_lat", lat, 10);
        check_eq("ign_prod", product, 16'h000F);
        extra = 0;
        repeat (15) begin
            step();
            if (done) extra++;
        end
        check_eq("ign_nodone", extra, 0);
        last_exp = 16'h000F;

        // back-to-back with start held high
        a = 8'h12; b = 8'h34; start = 1'b1;
        step();
        a = 8'h56; b = 8'h78;
        wait_done(1, lat, bcnt);
        check_eq("b2b1_lat", lat, 10);
        check_eq("b2b1_prod", product, 16'h03A8);
        check_eq("b2b1_busy", busy, 1'b0);
        step();
        start = 1'b0;
        a = 8'h00; b = 8'h00;
        check_eq("b2b2_busy", busy, 1'b1);
        check_eq("b2b2_hold", product, 16'h03A8);
        wait_done(1, lat, bcnt);
        check_eq("b2b2_lat", lat, 10);
        check_eq("b2b2_prod", product, 16'h2850);
        step();
        check_eq("b2b2_donew", done, 1'b0);

        // asynchronous reset mid-operation
        a = 8'hAB; b = 8'hCD; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check_eq("mid_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_prod", product, 16'h0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            step();
            if (done || busy) extra++;
        end
        check_eq("arst_idle", extra, 0);
        last_exp = 16'h0;
        do_mult(8'h10, 8'h10, "post");

        for (int i = 0; i < 1000; i++) begin
            do_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
